// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter that sends whole frames from several requesters through one uart_tx
module uart_tx_scheduler #(
  parameter int _NUM_REQ      = 4,
  parameter int _MAX_BYTES    = 8,
  parameter int _GAP_CYCLES   = 16,
  parameter int _BUSY_TIMEOUT = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [_NUM_REQ-1:0]                 req,
  input  logic [_NUM_REQ*4-1:0]               req_len,
  input  logic [_NUM_REQ*_MAX_BYTES*8-1:0]    req_data,
  output logic [_NUM_REQ-1:0]                 req_done,
  output logic                                tx_en,
  output logic [7:0]                          tx_data,
  input  logic                                tx_busy,
  output logic                                busy,
  output logic [$clog2(_NUM_REQ)-1:0]         owner,
  output logic                                timeout_err
);
  localparam int OW = $clog2(_NUM_REQ);
  localparam int GW = $clog2(_GAP_CYCLES) + 1;
  localparam int TW = $clog2(_BUSY_TIMEOUT) + 1;
  localparam int DW = _MAX_BYTES * 8;
  typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, GAP, DONE} state_t;
  state_t state_q, state_d, exit_state;
  logic [OW-1:0] ptr_q, ptr_d, owner_q, owner_d, gnt;
  logic [3:0] idx_q, idx_d, len_q, len_d, exit_idx, rlen;
  logic [DW-1:0] data_q, data_d, rdata;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] to_q, to_d;
  logic busy_q, busy_d, tx_en_q, tx_en_d, terr_q, terr_d, found, last;
  logic [7:0] tx_data_q, tx_data_d, cur;
  logic [_NUM_REQ-1:0] done_q, done_d;
  logic [2*_NUM_REQ-1:0] rr;
  // rotate so bit 0 is the requester at the pointer; first set bit wins
  assign rr = {req, req} >> ptr_q;
  always_comb begin
    found = 1'b0;
    gnt = '0;
    for (int i = 0; i < _NUM_REQ; i++) begin
      if (!found && rr[i]) begin
        found = 1'b1;
        gnt = OW'((int'(ptr_q) + i) % _NUM_REQ);
      end
    end
  end
  always_comb begin
    rlen = '0;
    rdata = '0;
    for (int k = 0; k < _NUM_REQ; k++) begin
      if (gnt == OW'(k)) begin
        rlen = req_len[k*4 +: 4];
        rdata = req_data[k*DW +: DW];
      end
    end
  end
  always_comb begin
    cur = '0;
    for (int k = 0; k < _MAX_BYTES; k++) cur = (idx_q == 4'(k)) ? data_q[k*8 +: 8] : cur;
  end
  assign last = idx_q == len_q - 4'd1;
  assign exit_state = last ? DONE : (_GAP_CYCLES == 0 ? SEND : GAP);
  assign exit_idx = last ? idx_q : idx_q + 4'd1;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    idx_d = idx_q;
    len_d = len_q;
    data_d = data_q;
    gap_d = gap_q;
    to_d = to_q;
    busy_d = busy_q;
    tx_en_d = 1'b0;
    tx_data_d = tx_data_q;
    terr_d = terr_q;
    done_d = '0;
    case (state_q)
      IDLE: if (found) begin
        owner_d = gnt;
        busy_d = 1'b1;
        data_d = rdata;
        len_d = rlen > 4'(_MAX_BYTES) ? 4'(_MAX_BYTES) : rlen;
        idx_d = '0;
        state_d = rlen == 4'd0 ? DONE : SEND;
      end
      SEND: if (!tx_busy) begin
        tx_en_d = 1'b1;
        tx_data_d = cur;
        to_d = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: if (tx_busy) state_d = WAIT_LO;
      else if (to_q == TW'(_BUSY_TIMEOUT - 1)) begin
        terr_d = 1'b1;
        gap_d = '0;
        idx_d = exit_idx;
        state_d = exit_state;
      end else to_d = to_q + 1'b1;
      WAIT_LO: if (!tx_busy) begin
        gap_d = '0;
        idx_d = exit_idx;
        state_d = exit_state;
      end
      GAP: if (gap_q == GW'(_GAP_CYCLES - 1)) state_d = SEND;
      else gap_d = gap_q + 1'b1;
      DONE: begin
        done_d[owner_q] = 1'b1;
        busy_d = 1'b0;
        ptr_d = owner_q == OW'(_NUM_REQ - 1) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      idx_q <= '0;
      len_q <= '0;
      data_q <= '0;
      gap_q <= '0;
      to_q <= '0;
      busy_q <= 1'b0;
      tx_en_q <= 1'b0;
      tx_data_q <= '0;
      terr_q <= 1'b0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      idx_q <= idx_d;
      len_q <= len_d;
      data_q <= data_d;
      gap_q <= gap_d;
      to_q <= to_d;
      busy_q <= busy_d;
      tx_en_q <= tx_en_d;
      tx_data_q <= tx_data_d;
      terr_q <= terr_d;
      done_q <= done_d;
    end
  end
  assign req_done = done_q;
  assign tx_en = tx_en_q;
  assign tx_data = tx_data_q;
  assign busy = busy_q;
  assign owner = owner_q;
  assign timeout_err = terr_q;
endmodule
